// File: rtl/controle_seq_pkg.sv
// rtl/controle_seq_pkg.sv - encodings, opcodes and state type for the sequencing controller
package controle_pkg;

  localparam logic [1:0] LIMPARXZ   = 2'b00;
  localparam logic [1:0] CARREGARXZ = 2'b01;
  localparam logic [1:0] MANTERXZ   = 2'b10;
  localparam logic [1:0] DESLOCXZ   = 2'b11;

  localparam logic [2:0] LIMPARY    = 3'b000;
  localparam logic [2:0] CARREGARY  = 3'b001;
  localparam logic [2:0] MANTERY    = 3'b010;
  localparam logic [2:0] SESQUERDAY = 3'b011;
  localparam logic [2:0] SDIREITAY  = 3'b100;

  localparam logic SOMAULA = 1'b0;
  localparam logic SUBULA  = 1'b1;

  localparam logic [2:0] OP_SOMA   = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_SHL_Y  = 3'b010;
  localparam logic [2:0] OP_SHR_Y  = 3'b011;
  localparam logic [2:0] OP_MUL    = 3'b100;
  localparam logic [2:0] OP_LIMPAR = 3'b101;

  typedef enum logic [2:0] {
    IDLE, CLR, LOAD_X, LOAD_Y, EXEC, MUL, DONE
  } state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_LIMPAR;
  endfunction

endpackage

// File: rtl/controle_seq_if.sv
// rtl/controle_seq_if.sv - decoder/datapath side signals of the sequencing controller
interface controle_seq_if;
  logic       start;
  logic [2:0] op;
  logic       y_lsb;
  logic       y_zero;
  logic [1:0] auxX;
  logic [2:0] auxY;
  logic [1:0] auxZ;
  logic       auxULA;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, op, y_lsb, y_zero,
    input  auxX, auxY, auxZ, auxULA, busy, done, err
  );

  modport slave (
    input  start, op, y_lsb, y_zero,
    output auxX, auxY, auxZ, auxULA, busy, done, err
  );
endinterface

// File: rtl/controle_seq_contador_iter.sv
// rtl/controle_seq_contador_iter.sv - multiply iteration counter with terminal flag at WIDTH-1
module contador_iter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr)
      cnt <= '0;
    else if (en)
      cnt <= cnt + 1'b1;
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/controle_seq.sv
// rtl/controle_seq.sv - start/done sequencer driving the X/Y/Z register and ULA control lines
module controle_seq
  import controle_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int CNT_W      = $clog2(WIDTH + 1),
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  controle_seq_if.slave  bus
);

  state_t     state;
  logic [2:0] op_r;
  logic       cnt_last;
  logic       y_exit;
  logic       mul_exit;

  // A zero Y multiplier ends the loop before any register update that cycle.
  assign y_exit   = EARLY_EXIT && bus.y_zero;
  assign mul_exit = (state == MUL) && (y_exit || cnt_last);

  contador_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  ((state != MUL) || mul_exit),
    .en   (state == MUL),
    .last (cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_r  <= OP_SOMA;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_r <= bus.op;
            if (bus.op == OP_LIMPAR)
              state <= CLR;
            else if (!op_legal(bus.op))
              state <= DONE;
            else
              state <= LOAD_X;
          end
        end
        CLR:     state <= DONE;
        LOAD_X:  state <= LOAD_Y;
        LOAD_Y:  state <= (op_r == OP_MUL) ? MUL : EXEC;
        EXEC:    state <= DONE;
        MUL:     if (mul_exit) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    bus.auxX   = MANTERXZ;
    bus.auxY   = MANTERY;
    bus.auxZ   = MANTERXZ;
    bus.auxULA = SOMAULA;
    bus.busy   = (state != IDLE);
    bus.done   = 1'b0;
    bus.err    = 1'b0;
    case (state)
      CLR: begin
        bus.auxX = LIMPARXZ;
        bus.auxY = LIMPARY;
        bus.auxZ = LIMPARXZ;
      end
      LOAD_X: begin
        bus.auxX = CARREGARXZ;
        if (op_r == OP_MUL) bus.auxZ = LIMPARXZ;
      end
      LOAD_Y: bus.auxY = CARREGARY;
      EXEC: begin
        case (op_r)
          OP_SOMA, OP_SUB: begin
            bus.auxZ   = CARREGARXZ;
            bus.auxULA = op_r[0];
          end
          OP_SHL_Y: bus.auxY = SESQUERDAY;
          OP_SHR_Y: bus.auxY = SDIREITAY;
          default:  ;
        endcase
      end
      MUL: begin
        // Z accumulates X before X and Y shift; all three use pre-edge values.
        if (!y_exit) begin
          bus.auxX = DESLOCXZ;
          bus.auxY = SDIREITAY;
          bus.auxZ = bus.y_lsb ? CARREGARXZ : MANTERXZ;
        end
      end
      DONE: begin
        bus.done = 1'b1;
        bus.err  = !op_legal(op_r);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_controle_seq.sv
// tb/tb_controle_seq.sv - randomized bench comparing two controller variants to a cycle-trace model
module tb_controle_seq;

  localparam int W = 4;
  localparam logic [10:0] IDLE_V = {2'b10, 3'b010, 2'b10, 4'b0000};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  controle_seq_if if_a ();
  controle_seq_if if_b ();

  controle_seq #(.WIDTH(W), .EARLY_EXIT(1'b0)) dut_a (.clk(clk), .rst(rst), .bus(if_a.slave));
  controle_seq #(.WIDTH(W), .EARLY_EXIT(1'b1)) dut_b (.clk(clk), .rst(rst), .bus(if_b.slave));

  logic       start_v [2];
  logic [2:0] op_v;
  logic       yl_v, yz_v;

  assign if_a.start  = start_v[0];
  assign if_b.start  = start_v[1];
  assign if_a.op     = op_v;
  assign if_b.op     = op_v;
  assign if_a.y_lsb  = yl_v;
  assign if_b.y_lsb  = yl_v;
  assign if_a.y_zero = yz_v;
  assign if_b.y_zero = yz_v;

  logic [10:0] obs [2];
  assign obs[0] = {if_a.auxX, if_a.auxY, if_a.auxZ, if_a.auxULA, if_a.busy, if_a.done, if_a.err};
  assign obs[1] = {if_b.auxX, if_b.auxY, if_b.auxZ, if_b.auxULA, if_b.busy, if_b.done, if_b.err};

  logic        yl_a [0:63];
  logic        yz_a [0:63];
  logic [10:0] ex [2][0:63];
  int          ex_len [2];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %03h expected %03h", tag, got, want);
    end
  endtask

  function automatic logic [10:0] vec(input logic [1:0] x, input logic [2:0] y, input logic [1:0] z,
                                      input logic u, input logic b, input logic d, input logic e);
    return {x, y, z, u, b, d, e};
  endfunction

  task automatic push(input int d, input logic [10:0] v);
    ex[d][ex_len[d]] = v;
    ex_len[d]++;
  endtask

  // Expected per-cycle outputs starting at cycle 1 after the start edge.
  task automatic build(input int d, input bit ee, input logic [2:0] op);
    int c;
    ex_len[d] = 0;
    case (op)
      3'd0, 3'd1, 3'd2, 3'd3: begin
        push(d, vec(2'b01, 3'b010, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0));
        push(d, vec(2'b10, 3'b001, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0));
        if (op == 3'd0)      push(d, vec(2'b10, 3'b010, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0));
        else if (op == 3'd1) push(d, vec(2'b10, 3'b010, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0));
        else if (op == 3'd2) push(d, vec(2'b10, 3'b011, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0));
        else                 push(d, vec(2'b10, 3'b100, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0));
        push(d, vec(2'b10, 3'b010, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0));
      end
      3'd4: begin
        push(d, vec(2'b01, 3'b010, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
        push(d, vec(2'b10, 3'b001, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0));
        c = 3;
        for (int i = 0; i < W; i++) begin
          if (ee && yz_a[c]) begin
            push(d, vec(2'b10, 3'b010, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0));
            break;
          end
          push(d, vec(2'b11, 3'b100, yl_a[c] ? 2'b01 : 2'b10, 1'b0, 1'b1, 1'b0, 1'b0));
          c++;
        end
        push(d, vec(2'b10, 3'b010, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0));
      end
      3'd5: begin
        push(d, vec(2'b00, 3'b000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0));
        push(d, vec(2'b10, 3'b010, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0));
      end
      default: push(d, vec(2'b10, 3'b010, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1));
    endcase
  endtask

  task automatic clear_status();
    for (int i = 0; i < 64; i++) begin
      yl_a[i] = 1'b0;
      yz_a[i] = 1'b0;
    end
  endtask

  task automatic gen_status(input int p_zero);
    for (int i = 0; i < 64; i++) begin
      yl_a[i] = 1'($urandom % 2);
      yz_a[i] = (($urandom % p_zero) == 0);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input int rst_at, input bit hold_start, input string name);
    int maxlen;
    build(0, 1'b0, op);
    build(1, 1'b1, op);
    for (int d = 0; d < 2; d++)
      if (rst_at > 0 && ex_len[d] > rst_at) ex_len[d] = rst_at;
    maxlen = ((ex_len[0] > ex_len[1]) ? ex_len[0] : ex_len[1]) + 1;
    @(negedge clk);
    start_v[0] = 1'b1;
    start_v[1] = 1'b1;
    op_v = op;
    yl_v = yl_a[0];
    yz_v = yz_a[0];
    #1;
    for (int d = 0; d < 2; d++)
      check_eq($sformatf("%s dut%0d cyc0", name, d), 32'(obs[d]), 32'(IDLE_V));
    for (int k = 1; k <= maxlen; k++) begin
      @(negedge clk);
      rst  = (rst_at > 0 && k == rst_at);
      yl_v = yl_a[k];
      yz_v = yz_a[k];
      op_v = 3'($urandom % 8);
      for (int d = 0; d < 2; d++)
        start_v[d] = (k <= ex_len[d]) ? (hold_start ? 1'b1 : 1'($urandom % 2)) : 1'b0;
      #1;
      for (int d = 0; d < 2; d++)
        check_eq($sformatf("%s dut%0d cyc%0d", name, d, k), 32'(obs[d]),
                 32'((k <= ex_len[d]) ? ex[d][k-1] : IDLE_V));
    end
    rst = 1'b0;
  endtask

  initial begin
    start_v[0] = 1'b0;
    start_v[1] = 1'b0;
    op_v = 3'd0;
    yl_v = 1'b0;
    yz_v = 1'b0;
    rst  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_eq("reset dut0", 32'(obs[0]), 32'(IDLE_V));
    check_eq("reset dut1", 32'(obs[1]), 32'(IDLE_V));
    rst = 1'b0;

    clear_status();
    run_op(3'd0, 0, 1'b0, "soma");
    run_op(3'd1, 0, 1'b0, "sub");
    run_op(3'd3, 0, 1'b0, "shr");
    run_op(3'd2, 0, 1'b0, "shl");
    run_op(3'd5, 0, 1'b0, "limpar");

    clear_status();
    yl_a[3] = 1'b1; yl_a[4] = 1'b0; yl_a[5] = 1'b1; yl_a[6] = 1'b1;
    run_op(3'd4, 0, 1'b0, "mul_1011");

    gen_status(1000000);
    yz_a[4] = 1'b1;
    run_op(3'd4, 0, 1'b0, "mul_early");

    gen_status(1000000);
    yz_a[3] = 1'b1;
    run_op(3'd4, 0, 1'b0, "mul_entry");

    clear_status();
    for (int i = 0; i < 64; i++) yl_a[i] = 1'b1;
    run_op(3'd4, 5, 1'b0, "mul_rst");
    run_op(3'd0, 0, 1'b0, "after_rst");

    run_op(3'd6, 0, 1'b0, "illegal6");
    run_op(3'd7, 0, 1'b0, "illegal7");
    run_op(3'd0, 0, 1'b1, "soma_hold");
    run_op(3'd4, 0, 1'b1, "mul_hold");

    for (int t = 0; t < 40; t++) begin
      gen_status(5);
      run_op(3'($urandom % 8), (($urandom % 6) == 0) ? int'($urandom_range(1, 6)) : 0,
             1'($urandom % 2), $sformatf("rand%0d", t));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
